// File: rtl/legacyver_sched.sv
// rtl/legacyver_sched.sv - two-requester round-robin scheduler for the legacyver datapath
module legacyver_sched #(
   parameter int AW  = 4,
   parameter int DW  = 8,
   parameter int LAT = 2,
   parameter int TMO = 15
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [AW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [AW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   output logic [AW-1:0] dp_in0,
   output logic [DW-1:0] dp_in1,
   output logic          dp_issue,
   input  logic [3:0]    dp_out1,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_id,
   output logic [3:0]    rsp_data,
   output logic          busy,
   output logic          err,
   input  logic          err_clr
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_issue;
   logic          w_rsp_valid;
   logic          w_drop;
   logic          r_last_gnt;
   logic          r_id;
   logic [2:0]    r_wcnt;
   logic [7:0]    r_tmo;
   logic [AW-1:0] r_dp_in0;
   logic [DW-1:0] r_dp_in1;
   logic [3:0]    r_rsp_data;
   logic          r_err;

   // State register; reset abandons any in-flight operation
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state, grant and strobe decode
   always_comb begin
      w_next      = r_state;
      w_gnt0      = 1'b0;
      w_gnt1      = 1'b0;
      w_issue     = 1'b0;
      w_rsp_valid = 1'b0;
      w_drop      = 1'b0;
      case (r_state)
         S_IDLE: begin
            // On a tie the requester that did not win last time goes first
            w_gnt0 = req0_valid & (~req1_valid | r_last_gnt);
            w_gnt1 = req1_valid & (~req0_valid | ~r_last_gnt);
            if (w_gnt0 | w_gnt1) w_next = S_ISSUE;
         end
         S_ISSUE: begin
            w_issue = 1'b1;
            w_next  = S_WAIT;
         end
         S_WAIT: begin
            if (r_wcnt == 3'd0) w_next = S_RESP;
         end
         S_RESP: begin
            w_rsp_valid = 1'b1;
            // A handshake on the final allowed cycle still delivers the response
            if (rsp_ready) begin
               w_next = S_IDLE;
            end else if (r_tmo == 8'(TMO - 1)) begin
               w_drop = 1'b1;
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operand capture and round-robin history on an accepted request
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_dp_in0   <= '0;
         r_dp_in1   <= '0;
         r_id       <= 1'b0;
         r_last_gnt <= 1'b1;
      end else if (w_gnt0) begin
         r_dp_in0   <= req0_a;
         r_dp_in1   <= req0_b;
         r_id       <= 1'b0;
         r_last_gnt <= 1'b0;
      end else if (w_gnt1) begin
         r_dp_in0   <= req1_a;
         r_dp_in1   <= req1_b;
         r_id       <= 1'b1;
         r_last_gnt <= 1'b1;
      end
   end

   // Latency countdown and result capture when the datapath output is due
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wcnt     <= 3'd0;
         r_rsp_data <= 4'd0;
      end else if (r_state == S_ISSUE) begin
         r_wcnt <= 3'(LAT - 1);
      end else if (r_state == S_WAIT) begin
         if (r_wcnt == 3'd0) r_rsp_data <= dp_out1;
         else                r_wcnt     <= r_wcnt - 3'd1;
      end
   end

   // Counts unacknowledged response cycles; restarts for each response
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tmo <= 8'd0;
      end else if (r_state != S_RESP) begin
         r_tmo <= 8'd0;
      end else if (!rsp_ready) begin
         r_tmo <= r_tmo + 8'd1;
      end
   end

   // Sticky drop flag; a new drop takes priority over a clear
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)        r_err <= 1'b0;
      else if (w_drop)  r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
   end

   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;
   assign dp_in0     = r_dp_in0;
   assign dp_in1     = r_dp_in1;
   assign dp_issue   = w_issue;
   assign rsp_valid  = w_rsp_valid;
   assign rsp_id     = r_id;
   assign rsp_data   = r_rsp_data;
   assign busy       = (r_state != S_IDLE);
   assign err        = r_err;

endmodule

// File: tb/tb_legacyver_sched.sv
// tb/tb_legacyver_sched.sv - randomized self-checking bench for legacyver_sched
module tb_legacyver_sched;

   localparam int AW  = 4;
   localparam int DW  = 8;
   localparam int LAT = 2;
   localparam int TMO = 15;

   logic          clk = 1'b0;
   logic          rstn;
   logic          req0_valid, req1_valid;
   logic          req0_ready, req1_ready;
   logic [AW-1:0] req0_a, req1_a;
   logic [DW-1:0] req0_b, req1_b;
   logic [AW-1:0] dp_in0;
   logic [DW-1:0] dp_in1;
   logic          dp_issue;
   logic [3:0]    dp_out1;
   logic          rsp_valid, rsp_ready, rsp_id;
   logic [3:0]    rsp_data;
   logic          busy, err, err_clr;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            cyc = 0;
   logic [3:0]    hist [int];
   int            last_w;
   logic          exp_err;

   always #5 clk = ~clk;

   legacyver_sched #(.AW(AW), .DW(DW), .LAT(LAT), .TMO(TMO)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .dp_in0(dp_in0), .dp_in1(dp_in1), .dp_issue(dp_issue), .dp_out1(dp_out1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
      .busy(busy), .err(err), .err_clr(err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; the datapath model presents a fresh random result every cycle
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      dp_out1 = 4'($urandom);
      hist[cyc] = dp_out1;
   endtask

   // One full operation starting in a cycle where the scheduler should be idle.
   // hold = cycles rsp_ready stays low in RESP; hold >= TMO means the response is dropped.
   task automatic do_txn(input bit v0, input bit v1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                         input int hold, input bit clr);
      int            w, t0, last_k;
      bit            drop;
      logic [AW-1:0] ea;
      logic [DW-1:0] eb;
      logic [3:0]    ed;
      req0_valid = v0; req1_valid = v1;
      req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
      rsp_ready = 1'b0; err_clr = clr;
      #1;
      w = (v0 && v1) ? (1 - last_w) : (v1 ? 1 : 0);
      chk("idle_busy", busy, 0);
      chk("idle_rdy0", req0_ready, (w == 0));
      chk("idle_rdy1", req1_ready, (w == 1));
      last_w = w;
      t0 = cyc;
      ea = (w == 1) ? a1 : a0;
      eb = (w == 1) ? b1 : b0;
      drop = (hold >= TMO);

      tick();
      if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
      #1;
      chk("issue_strobe", dp_issue, 1);
      chk("issue_in0", dp_in0, ea);
      chk("issue_in1", dp_in1, eb);
      chk("issue_busy", busy, 1);
      chk("issue_rdy", {req0_ready, req1_ready}, 0);

      for (int k = 0; k < LAT; k++) begin
         tick();
         #1;
         chk("wait_strobe", dp_issue, 0);
         chk("wait_rsp", rsp_valid, 0);
         chk("wait_rdy", {req0_ready, req1_ready}, 0);
         chk("wait_in0", dp_in0, ea);
      end

      ed = hist[t0 + 1 + LAT];
      last_k = drop ? (TMO - 1) : hold;
      for (int k = 0; k <= last_k; k++) begin
         tick();
         rsp_ready = (k == hold);
         #1;
         chk("resp_valid", rsp_valid, 1);
         chk("resp_id", rsp_id, w);
         chk("resp_data", rsp_data, ed);
         chk("resp_rdy", {req0_ready, req1_ready}, 0);
      end

      tick();
      rsp_ready = 1'b0;
      err_clr = 1'b0;
      #1;
      if (drop)     exp_err = 1'b1;
      else if (clr) exp_err = 1'b0;
      chk("post_valid", rsp_valid, 0);
      chk("post_busy", busy, 0);
      chk("post_err", err, exp_err);
      chk("post_data", rsp_data, ed);
   endtask

   initial begin
      int v;
      rstn = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      rsp_ready = 1'b0; err_clr = 1'b0; dp_out1 = 4'd0;
      last_w = 1; exp_err = 1'b0;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
      chk("rst_dp", {dp_issue, dp_in0, dp_in1}, 0);
      chk("rst_err", err, 0);
      rstn = 1'b1;
      tick();

      // Basic operation from the example timing
      do_txn(1, 0, 4'h3, 4'h0, 8'hA5, 8'h00, 0, 0);
      // Both requesters continuously valid: grants must alternate
      for (int i = 0; i < 4; i++)
         do_txn(1, 1, 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom), 0, 0);
      // Response left unacknowledged for TMO cycles is dropped
      do_txn(0, 1, 4'h5, 4'h9, 8'h11, 8'h22, TMO, 0);
      // Clear pulse
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      exp_err = 1'b0;
      #1;
      chk("err_cleared", err, 0);
      // Acknowledge on the last allowed cycle: delivered, no error
      do_txn(1, 0, 4'hC, 4'h0, 8'h5A, 8'h00, TMO - 1, 0);
      // Drop while clear is held: setting wins
      do_txn(1, 1, 4'h1, 4'h2, 8'h33, 8'h44, TMO, 1);

      // Reset in WAIT abandons the operation and zeroes every output
      req0_valid = 1'b1; req1_valid = 1'b1;
      tick();
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      rstn = 1'b0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
      chk("mid_rst_dp", {dp_issue, dp_in0, dp_in1}, 0);
      chk("mid_rst_err", err, 0);
      chk("mid_rst_rdy", {req0_ready, req1_ready}, 0);
      tick();
      rstn = 1'b1;
      last_w = 1;
      exp_err = 1'b0;
      tick();
      do_txn(1, 1, 4'h7, 4'h8, 8'h77, 8'h88, 0, 0);

      // Randomized operations
      for (int i = 0; i < 30; i++) begin
         v = int'($urandom_range(1, 3));
         do_txn(v[0], v[1], 4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, TMO)), ($urandom_range(0, 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
